// File: rtl/sd_sector_bridge.sv
// Single-sector buffer between the hps_io SD block interface and the Einstein FDC.
// Runs the sd_rd/sd_wr/sd_ack handshake and keeps a one-entry sector cache.
module sd_sector_bridge #(
    parameter int          DRIVES  = 2,
    parameter logic [23:0] TIMEOUT = 24'd8000000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       req_lba,
    input  logic              req_drive,
    input  logic              req_rd,
    input  logic              req_wr,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [8:0]        fdc_addr,
    input  logic [7:0]        fdc_din,
    input  logic              fdc_we,
    output logic [7:0]        fdc_dout,
    output logic [DRIVES-1:0] mounted,
    output logic [31:0]       sd_lba,
    output logic [DRIVES-1:0] sd_rd,
    output logic [DRIVES-1:0] sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    output logic [7:0]        sd_buff_din,
    input  logic              sd_buff_wr,
    input  logic [DRIVES-1:0] img_mounted,
    input  logic [63:0]       img_size
);

    typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, RD_XFER, WR_XFER, FINISH} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       lba_reg, lba_next;
    logic              drive_reg, drive_next;
    logic              fail_reg, fail_next;
    logic              err_reg, err_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [23:0]       timer_reg, timer_next;
    logic              cache_valid_reg;
    logic [31:0]       cache_lba_reg;
    logic              cache_drive_reg;
    logic [DRIVES-1:0] mounted_reg, mounted_next;
    logic [DRIVES-1:0] mount_hit_bits;
    logic              cache_set, cache_clr_req, fdc_wr_en, hps_wr_en;

    logic [7:0] ram [0:511];

    assign fdc_wr_en = fdc_we && (state_reg != RD_XFER);
    assign hps_wr_en = sd_buff_wr && sd_ack && (state_reg == RD_XFER);

    genvar gi;
    generate
        for (gi = 0; gi < DRIVES; gi++) begin : g_drive
            assign sd_rd[gi]          = (state_reg == RD_REQ) && (drive_reg == 1'(gi));
            assign sd_wr[gi]          = (state_reg == WR_REQ) && (drive_reg == 1'(gi));
            assign mounted_next[gi]   = img_mounted[gi] ? (img_size != 64'd0) : mounted_reg[gi];
            assign mount_hit_bits[gi] = img_mounted[gi] && (cache_drive_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        lba_next      = lba_reg;
        drive_next    = drive_reg;
        fail_next     = fail_reg;
        err_next      = err_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        cache_set     = 1'b0;
        cache_clr_req = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_rd || req_wr) begin
                    busy_next  = 1'b1;
                    err_next   = 1'b0;
                    fail_next  = 1'b0;
                    lba_next   = req_lba;
                    drive_next = req_drive;
                    if (!mounted_reg[req_drive]) begin
                        fail_next  = 1'b1;
                        state_next = FINISH;
                    end else if (req_wr) begin
                        state_next = WR_REQ;
                    end else if (cache_valid_reg && req_lba == cache_lba_reg &&
                                 req_drive == cache_drive_reg) begin
                        state_next = FINISH;
                    end else begin
                        cache_clr_req = 1'b1;
                        state_next    = RD_REQ;
                    end
                end
            end
            RD_REQ, WR_REQ: begin
                if (sd_ack) begin
                    state_next = (state_reg == RD_REQ) ? RD_XFER : WR_XFER;
                end else if (timer_reg >= TIMEOUT - 24'd1) begin
                    fail_next  = 1'b1;
                    state_next = FINISH;
                end
            end
            RD_XFER, WR_XFER: begin
                // Either direction leaves the buffer mirroring the sector on disk.
                if (!sd_ack) begin
                    cache_set  = 1'b1;
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                err_next   = fail_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        timer_next = timer_reg;
        if (state_next != state_reg)
            timer_next = 24'd0;
        else if (timer_reg != 24'hFFFFFF)
            timer_next = timer_reg + 24'd1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            lba_reg         <= 32'd0;
            drive_reg       <= 1'b0;
            fail_reg        <= 1'b0;
            err_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timer_reg       <= 24'd0;
            mounted_reg     <= '0;
            cache_valid_reg <= 1'b0;
            cache_lba_reg   <= 32'd0;
            cache_drive_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lba_reg     <= lba_next;
            drive_reg   <= drive_next;
            fail_reg    <= fail_next;
            err_reg     <= err_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            timer_reg   <= timer_next;
            mounted_reg <= mounted_next;
            if (cache_set) begin
                cache_valid_reg <= 1'b1;
                cache_lba_reg   <= lba_reg;
                cache_drive_reg <= drive_reg;
            end
            // Invalidation wins over a same-cycle fill: the buffer or image changed.
            if (cache_clr_req || fdc_wr_en || (|mount_hit_bits))
                cache_valid_reg <= 1'b0;
        end
    end

    // The two write ports are mutually exclusive by state.
    always_ff @(posedge clk_sys) begin
        if (fdc_wr_en)
            ram[fdc_addr] <= fdc_din;
        if (hps_wr_en)
            ram[sd_buff_addr] <= sd_buff_dout;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            fdc_dout    <= 8'd0;
            sd_buff_din <= 8'd0;
        end else begin
            fdc_dout    <= ram[fdc_addr];
            sd_buff_din <= ram[sd_buff_addr];
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign sd_lba  = lba_reg;
    assign mounted = mounted_reg;

endmodule

// File: tb/tb_sd_sector_bridge.sv
// Directed bench for sd_sector_bridge: read, cache hit, write, errors, timeout, reset.
module tb_sd_sector_bridge;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] req_lba;
    logic        req_drive, req_rd, req_wr;
    logic        busy, done, err;
    logic [8:0]  fdc_addr;
    logic [7:0]  fdc_din, fdc_dout;
    logic        fdc_we;
    logic [1:0]  mounted, sd_rd, sd_wr, img_mounted;
    logic [31:0] sd_lba;
    logic        sd_ack, sd_buff_wr;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic [63:0] img_size;

    int total = 0;
    int bad   = 0;
    int n;
    int extra;

    always #5 clk_sys = ~clk_sys;

    sd_sector_bridge #(.DRIVES(2), .TIMEOUT(24'd100)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .req_lba(req_lba), .req_drive(req_drive), .req_rd(req_rd), .req_wr(req_wr),
        .busy(busy), .done(done), .err(err),
        .fdc_addr(fdc_addr), .fdc_din(fdc_din), .fdc_we(fdc_we), .fdc_dout(fdc_dout),
        .mounted(mounted), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .img_mounted(img_mounted), .img_size(img_size)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < limit) begin
            tick();
            cnt++;
        end
        chk("done_seen", 64'(cnt < limit), 64'd1);
    endtask

    task automatic mount0();
        img_mounted = 2'b01;
        img_size    = 64'd204800;
        tick();
        img_mounted = 2'b00;
    endtask

    initial begin
        reset = 1'b1; req_lba = 0; req_drive = 0; req_rd = 0; req_wr = 0;
        fdc_addr = 0; fdc_din = 0; fdc_we = 0; sd_ack = 0; sd_buff_wr = 0;
        sd_buff_addr = 0; sd_buff_dout = 0; img_mounted = 0; img_size = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_mounted", mounted, 0);
        chk("rst_fdc_dout", fdc_dout, 0);
        chk("rst_buff_din", sd_buff_din, 0);
        reset = 1'b0;
        tick();

        mount0();
        tick();
        chk("mount0", mounted, 2'b01);
        $display("txn mount drive0 size=204800 mounted=%b", mounted);

        req_lba = 5; req_drive = 0; req_rd = 1;
        tick();
        req_rd = 0;
        chk("rd_sd_rd", sd_rd, 2'b01);
        chk("rd_busy", busy, 1);
        chk("rd_sd_lba", sd_lba, 5);
        tick(); tick();
        chk("rd_sd_rd_hold", sd_rd, 2'b01);
        sd_ack = 1;
        tick();
        chk("rd_sd_rd_drop", sd_rd, 2'b00);
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'(i) ^ 8'hA5;
            sd_buff_wr   = 1;
            tick();
        end
        sd_buff_wr = 0; sd_ack = 0;
        tick();
        wait_done(10, n);
        chk("rd_err", err, 0);
        chk("rd_busy_fall", busy, 0);
        fdc_addr = 3;
        tick();
        chk("rd_data3", fdc_dout, 8'hA6);
        $display("txn read lba=5 drive=0 err=%0d data3=%h", err, fdc_dout);

        req_lba = 5; req_drive = 0; req_rd = 1;
        tick();
        req_rd = 0;
        chk("hit_no_sd_rd", sd_rd, 0);
        chk("hit_busy", busy, 1);
        tick();
        chk("hit_done_2cyc", done, 1);
        chk("hit_err", err, 0);
        chk("hit_no_sd_rd2", sd_rd, 0);
        $display("txn cached read lba=5 done=%0d", done);
        tick();

        fdc_addr = 0; fdc_din = 8'h11; fdc_we = 1;
        tick();
        fdc_we = 0;
        chk("fdcwe_inval", dut.cache_valid_reg, 0);
        req_lba = 5; req_drive = 0; req_rd = 1;
        tick();
        req_rd = 0;
        chk("reread_sd_rd", sd_rd, 2'b01);
        sd_ack = 1; tick(); sd_ack = 0; tick();
        wait_done(10, n);
        $display("txn reread lba=5 after fdc write sd_rd seen");
        tick();

        fdc_addr = 9'd511; fdc_din = 8'h3C; fdc_we = 1;
        tick();
        fdc_we = 0;
        req_lba = 9; req_drive = 0; req_wr = 1;
        tick();
        req_wr = 0;
        chk("wr_sd_wr", sd_wr, 2'b01);
        chk("wr_sd_rd", sd_rd, 0);
        chk("wr_sd_lba", sd_lba, 9);
        sd_ack = 1;
        tick();
        chk("wr_sd_wr_drop", sd_wr, 0);
        sd_buff_addr = 9'd511;
        tick();
        chk("wr_buff_din", sd_buff_din, 8'h3C);
        sd_ack = 0;
        tick();
        wait_done(10, n);
        chk("wr_err", err, 0);
        $display("txn write lba=9 err=%0d", err);
        tick();

        req_lba = 9; req_drive = 0; req_rd = 1;
        tick();
        req_rd = 0;
        chk("wr_then_hit", sd_rd, 0);
        tick();
        chk("wr_then_hit_done", done, 1);
        tick();

        req_lba = 7; req_drive = 1; req_rd = 1;
        tick();
        req_rd = 0;
        chk("unm_no_sd_rd", sd_rd, 0);
        tick();
        chk("unm_done", done, 1);
        chk("unm_err", err, 1);
        $display("txn read drive=1 unmounted err=%0d", err);
        tick();

        req_lba = 20; req_drive = 0; req_rd = 1;
        tick();
        req_rd = 0;
        chk("to_sd_rd", sd_rd, 2'b01);
        wait_done(300, n);
        chk("to_cycle_window", 64'(n >= 98 && n <= 104), 1);
        chk("to_err", err, 1);
        chk("to_sd_rd_low", sd_rd, 0);
        $display("txn timeout read lba=20 cycles=%0d err=%0d", n + 1, err);
        tick();

        req_lba = 30; req_drive = 0; req_rd = 1; req_wr = 1;
        tick();
        req_rd = 0; req_wr = 0;
        chk("both_sd_wr", sd_wr, 2'b01);
        chk("both_sd_rd", sd_rd, 0);
        req_lba = 40; req_rd = 1;
        tick();
        req_rd = 0;
        chk("busy_drop_rd", sd_rd, 0);
        chk("busy_drop_lba", sd_lba, 30);
        sd_ack = 1; tick(); sd_ack = 0; tick();
        wait_done(10, n);
        chk("both_err", err, 0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || sd_rd !== 2'b00) extra++;
        end
        chk("single_done", extra, 0);
        $display("txn rd+wr same cycle lba=30 write only");

        req_lba = 50; req_drive = 0; req_rd = 1;
        tick();
        req_rd = 0;
        sd_ack = 1;
        tick();
        reset = 1;
        #1;
        chk("arst_sd_rd", sd_rd, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cache", dut.cache_valid_reg, 0);
        chk("arst_mounted", mounted, 0);
        sd_ack = 0;
        tick();
        reset = 0;
        tick();
        mount0();
        tick();
        req_lba = 50; req_drive = 0; req_rd = 1;
        tick();
        req_rd = 0;
        chk("post_rst_sd_rd", sd_rd, 2'b01);
        sd_ack = 1; tick(); sd_ack = 0; tick();
        wait_done(10, n);
        $display("txn reset in RD_XFER then reread lba=50");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_sector_bridge.md
Name: sd_sector_bridge

Overview:
- Single-sector (512-byte) buffer between the hps_io SD block interface and the Einstein floppy controller.
- The controller issues sector read or write requests by LBA and drive. The bridge runs the sd_rd/sd_wr/sd_ack handshake with the HPS and exposes the sector as byte-addressable dual-port RAM.
- A one-entry cache skips the SD transaction on repeated reads of the same sector.

Parameters:
- DRIVES, 2, number of image slots; sets the width of sd_rd, sd_wr and img_mounted.
- TIMEOUT, 24'd8000000, clk_sys cycles to wait for sd_ack before aborting with error.

Ports:
- clk_sys  in  1  system clock (40 MHz).
- reset  in  1  asynchronous, active-high reset.
- req_lba  in  32  sector LBA; sampled on req_rd/req_wr.
- req_drive  in  1  drive select; sampled on req_rd/req_wr.
- req_rd  in  1  one-cycle pulse: load the sector into the buffer.
- req_wr  in  1  one-cycle pulse: flush the buffer to the sector.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  status of the last completion; valid while done=1 and held until the next request is accepted.
- fdc_addr  in  9  controller-side buffer address.
- fdc_din  in  8  controller write data.
- fdc_we  in  1  controller buffer write strobe.
- fdc_dout  out  8  controller read data; 1-cycle latency.
- mounted  out  DRIVES  per-drive image-present flags.
- sd_lba  out  32  LBA presented to hps_io.
- sd_rd  out  DRIVES  per-drive read request.
- sd_wr  out  DRIVES  per-drive write request.
- sd_ack  in  1  HPS transfer acknowledge.
- sd_buff_addr  in  9  HPS-side buffer address.
- sd_buff_dout  in  8  HPS data into the buffer.
- sd_buff_din  out  8  buffer data to the HPS; 1-cycle latency from sd_buff_addr.
- sd_buff_wr  in  1  HPS write strobe.
- img_mounted  in  DRIVES  per-drive mount-change pulse.
- img_size  in  64  image size; qualified by img_mounted.

Behaviour:
- Reset values:
  - State IDLE.
  - busy=0, done=0, err=0.
  - sd_rd=0, sd_wr=0, sd_lba=0.
  - mounted=0, cache_valid=0, fdc_dout=0, sd_buff_din=0.
- Buffer:
  - 512x8 true dual-port RAM.
  - Port A is clk_sys/fdc side. Port B is HPS side: written only when sd_buff_wr=1 and sd_ack=1 and state=RD_XFER.
  - Controller writes (fdc_we) are accepted in any state, except that fdc_we is ignored in RD_XFER.
- Mount tracking:
  - On img_mounted[d], mounted[d] <= (img_size != 0).
  - If d equals the cached drive, cache_valid <= 0.
  - A mount pulse arriving mid-transfer still updates the flags; the current transfer completes normally.
- State machine: IDLE -> RD_REQ / WR_REQ -> RD_XFER / WR_XFER -> FINISH -> IDLE.
- IDLE:
  - req_rd with cache_valid and matching LBA/drive -> FINISH directly; no SD access, done two cycles after req_rd, err=0.
  - req_rd otherwise: latch LBA/drive into sd_lba, clear cache_valid, go to RD_REQ.
  - req_wr: latch LBA/drive, go to WR_REQ.
  - req_rd/req_wr targeting a drive with mounted=0 -> FINISH with err=1; no sd_rd/sd_wr is asserted.
  - req_rd and req_wr asserted in the same cycle: req_wr wins.
  - While busy=1, any requests are ignored (dropped, not queued).
- RD_REQ / WR_REQ:
  - Assert sd_rd[drive] or sd_wr[drive].
  - Hold it until sd_ack=1, then deassert it in the same edge and enter the XFER state.
  - If the TIMEOUT counter expires first: drop the request, go to FINISH with err=1.
- RD_XFER / WR_XFER:
  - Stay until sd_ack falls to 0, then go to FINISH.
  - RD_XFER exit sets cache_valid=1 with tag = latched LBA/drive.
  - WR_XFER exit sets cache_valid=1 for the written LBA, since the buffer now mirrors disk.
- FINISH: done=1 for exactly one cycle, busy falls in the same cycle, then IDLE.
- busy rises the cycle after an accepted request.
- Controller writes to the buffer while cache_valid=1 clear cache_valid. A subsequent req_rd of the same LBA therefore re-reads from SD.
- The timeout counter is 24-bit, cleared on state entry, and saturates.
- Async reset mid-transfer: all requests drop immediately, cache is invalidated, buffer contents are undefined.

Test Plan:
- Mount drive 0 with img_size=204800, then pulse req_rd with lba=5, drive=0. Required: sd_rd=2'b01 until sd_ack; HPS writes byte i=i^8'hA5 for i=0..511; ack falls. Then done=1, err=0, and fdc_dout at addr 3 is 8'hA6 one cycle after fdc_addr=3.
- Repeat req_rd with lba=5, drive=0. Required: sd_rd stays 0, done two cycles after the request. Then fdc_we at addr 0 followed by req_rd of lba=5 must assert sd_rd again.
- Controller writes 8'h3C at addr 511, then pulses req_wr with lba=9. Required: sd_wr=2'b01, sd_lba=9; during ack, sd_buff_din=8'h3C one cycle after sd_buff_addr=511; done=1, err=0.
- req_rd on drive 1 with mounted[1]=0. Required: no sd_rd, done with err=1. Also, req_rd with sd_ack never asserted and TIMEOUT=100 must give done with err=1 at about cycle 101 and sd_rd low afterwards.
- Pulse req_rd and req_wr in the same cycle. Required: a write transaction only. A second req_rd during busy must be ignored, producing exactly one done.
- Assert reset while in RD_XFER. Required: sd_rd=0, busy=0, cache_valid=0, mounted=0 immediately. After remount, a req_rd of the same LBA must assert sd_rd.
